cpu64_l1_refill_ctrl: RTL and testbench
=======================================

// Module: cpu64_l1_refill_ctrl
// PURPOSE
//  Sequences and arbitrates the L1 data/tag/state arrays between CPU store writes and line misses.
//  A miss runs victim select, dirty-victim writeback readout (8 beats) and refill write (8 beats).
//  Sits between the L1 pipeline/TileLink miss unit and the arrays; sole driver of the array write port.
// PARAMETERS
//  SETS     32   number of sets
//  WAYS     8    associativity; fixed at 8 (3-bit way select)
//  TAG_W    53   tag width
//  INDEX_W  5    set index width, log2(SETS)
// PORTS
//  clk_i              in   1            clock
//  rst_i              in   1            reset
//  cpu_wr_valid_i/ready_o  in/out 1     CPU store-hit write handshake
//  cpu_wr_index_i     in   INDEX_W      set index
//  cpu_wr_word_i      in   3            word in line
//  cpu_wr_way_i       in   3            hit way
//  cpu_wr_tag_i       in   TAG_W        tag of hit line (rewritten unchanged)
//  cpu_wr_state_i     in   2            state to write (normally TT)
//  cpu_wr_be_i        in   8            byte enables
//  cpu_wr_data_i      in   64           store data
//  miss_valid_i/ready_o    in/out 1     miss request handshake
//  miss_index_i       in   INDEX_W      miss set
//  miss_tag_i         in   TAG_W        miss tag
//  miss_state_i       in   2            granted state for new line
//  wb_valid_o/wb_ready_i   out/in 1     writeback beat handshake
//  wb_data_o          out  64           victim word
//  wb_tag_o           out  TAG_W        victim tag
//  wb_index_o         out  INDEX_W      victim set
//  wb_last_o          out  1            beat 7
//  fill_valid_i/ready_o    in/out 1     refill beat handshake
//  fill_data_i        in   64           refill word, beats in order 0..7
//  done_o             out  1            1-cycle pulse: miss complete
//  done_way_o         out  3            way filled
//  arr_index_o/word_sel_o/way_sel_o  out INDEX_W/3/3  array address
//  arr_write_en_o, arr_state_o, arr_be_o, arr_tag_o, arr_wdata_o  out  array write port
//  arr_rdata_selected_i, arr_tag_selected_i  in 64/TAG_W  combinational array reads
//  arr_state_way_flat_i  in  WAYS*2     per-way state at arr_index_o
// BEHAVIOUR
//  - Clock clk_i; reset rst_i is synchronous, active-high. All outputs 0 in reset; FSM=IDLE.
//  - FSM: IDLE -> VICTIM -> (EVICT if victim state==TT else FILL) -> FILL -> DONE -> IDLE.
//  - IDLE: cpu_wr_ready_o=1 and miss_ready_o=1 unless arbitration loses. Both valid: fairness bit
//    picks; bit=0 CPU wins, then bit set; granted miss clears it. CPU write is single-cycle,
//    arr_write_en_o asserted the same cycle combinationally from cpu_wr_* inputs.
//  - Non-IDLE: cpu_wr_ready_o=0, miss_ready_o=0. Miss fields latched on accept.
//  - VICTIM (1 cycle): arr_index_o=miss index; victim = lowest way with state N, else replacement policy.
//  - EVICT: word k=0..7 on arr_word_sel_o; wb_data_o=arr_rdata_selected_i; wb_valid_o=1; advance on
//    wb_valid_o&wb_ready_i; wb_last_o at k=7. wb_ready_i low holds beat stable. fill_ready_o=0.
//  - FILL: fill_ready_o=1; each accepted beat writes word k with be=8'hFF, tag=miss tag;
//    state=N for k=0..6, miss_state_i (latched) at k=7, so a partial line never appears valid.
//  - DONE: done_o=1 one cycle, done_way_o=victim; back to IDLE.
//  - Beat counter 3-bit, wraps 7->0 on leaving EVICT/FILL.
//  - Reset mid-miss: abort to IDLE next edge; partially filled line remains state N; no done_o.
//  - Min miss latency with clean victim and back-to-back fill: 1 accept + 1 VICTIM + 8 FILL + 1 DONE.
// CONFIGURATION
//  L1_PLRU_EN defined: per-set 7-bit tree pseudo-LRU (SETS x 7 flops, reset 0); updated on CPU
//    write (way touched) and at DONE (filled way); victim = PLRU-indicated way.
//  Undefined: single 3-bit round-robin counter, reset 0, victim=counter, increments when used.
//  Invalid-way-first rule applies in both modes.
// STRUCTURE
//  Shared params.vh: state encodings MESI_N=0, B=1, T=2, TT=3; LINE_BYTES; FSM state codes.
//  Sub-module cpu64_l1_victim_sel: invalid-way priority encoder plus PLRU/round-robin storage.
// TESTING
//  1 Reset, then CPU write idx=3 word=5 way=2 be=0x0F -> arr_write_en_o same cycle, ready=1.
//  2 Miss idx=4, all states B -> round-robin way 0, no wb beats, 8 fill beats, state N beats 0-6,
//    miss_state at beat 7, done_o at cycle 11, done_way_o=0.
//  3 Miss with way 3 state N among TT ways -> victim 3, no eviction.
//  4 All TT, wb_ready_i low 3 cycles on beat 2 -> wb_data_o stable, 8 beats wb_last_o on 8th, then fill.
//  5 CPU write and miss valid together twice -> CPU first, miss next; fairness alternates.
//  6 rst_i on fill beat 4 -> IDLE, done_o never asserted, line state stays N.

Source files
------------

// File: rtl/cpu64_l1_refill_ctrl_pkg.sv
// rtl/cpu64_l1_refill_ctrl_pkg.sv - shared encodings and tree-PLRU helpers for the L1 refill controller
package cpu64_l1_refill_ctrl_pkg;

    localparam int SETS       = 32;
    localparam int WAYS       = 8;
    localparam int TAG_W      = 53;
    localparam int INDEX_W    = 5;
    localparam int LINE_BYTES = 64;
    localparam int BEATS      = 8;

    typedef enum logic [1:0] {
        MESI_N  = 2'd0,
        MESI_B  = 2'd1,
        MESI_T  = 2'd2,
        MESI_TT = 2'd3
    } mesi_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VICTIM = 3'd1,
        ST_EVICT  = 3'd2,
        ST_FILL   = 3'd3,
        ST_DONE   = 3'd4
    } fsm_e;

    // Tree nodes: 0 = root, 1..2 = halves, 3..6 = pairs; each bit points toward the LRU side.
    function automatic logic [2:0] plru_victim(input logic [6:0] t);
        logic [2:0] v;
        logic [2:0] n1;
        logic [2:0] n2;
        v[2] = t[0];
        n1   = 3'd1 + {2'b00, v[2]};
        v[1] = t[n1];
        n2   = 3'd3 + {1'b0, v[2:1]};
        v[0] = t[n2];
        return v;
    endfunction

    function automatic logic [6:0] plru_touch(input logic [6:0] t, input logic [2:0] w);
        logic [6:0] r;
        logic [2:0] n1;
        logic [2:0] n2;
        r     = t;
        n1    = 3'd1 + {2'b00, w[2]};
        n2    = 3'd3 + {1'b0, w[2:1]};
        r[0]  = ~w[2];
        r[n1] = ~w[1];
        r[n2] = ~w[0];
        return r;
    endfunction

endpackage

// File: rtl/cpu64_l1_victim_sel.sv
// rtl/cpu64_l1_victim_sel.sv - invalid-way-first victim pick over PLRU (L1_PLRU_EN) or round-robin
module cpu64_l1_victim_sel
    import cpu64_l1_refill_ctrl_pkg::*;
#(
    parameter int SETS_P    = SETS,
    parameter int INDEX_W_P = INDEX_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [INDEX_W_P-1:0] index_i,
    input  logic [WAYS*2-1:0]    state_flat_i,
    input  logic                 use_i,
    input  logic                 touch_i,
    input  logic [INDEX_W_P-1:0] touch_index_i,
    input  logic [2:0]           touch_way_i,
    output logic [2:0]           victim_o,
    output logic                 invalid_hit_o
);

    logic [2:0] inv_way;
    logic [2:0] policy_way;

    always_comb begin
        invalid_hit_o = 1'b0;
        inv_way       = 3'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (state_flat_i[2*w +: 2] == MESI_N) begin
                invalid_hit_o = 1'b1;
                inv_way       = 3'(w);
            end
        end
    end

    assign victim_o = invalid_hit_o ? inv_way : policy_way;

`ifdef L1_PLRU_EN
    logic [6:0] plru_q [SETS_P];
    logic       unused_use;

    assign unused_use = use_i;
    assign policy_way = plru_victim(plru_q[index_i]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS_P; s++) plru_q[s] <= 7'd0;
        end else if (touch_i) begin
            plru_q[touch_index_i] <= plru_touch(plru_q[touch_index_i], touch_way_i);
        end
    end
`else
    logic [2:0]           rr_q;
    logic                 unused_touch;
    logic [INDEX_W_P-1:0] unused_touch_index;
    logic [INDEX_W_P-1:0] unused_index;
    logic [2:0]           unused_touch_way;

    assign unused_touch       = touch_i;
    assign unused_touch_index = touch_index_i;
    assign unused_index       = index_i;
    assign unused_touch_way   = touch_way_i;
    assign policy_way         = rr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) rr_q <= 3'd0;
        else if (use_i) rr_q <= rr_q + 3'd1;
    end
`endif

endmodule

// File: rtl/cpu64_l1_refill_ctrl.sv
// rtl/cpu64_l1_refill_ctrl.sv - L1 array arbiter and miss sequencer; L1_PLRU_EN selects tree-PLRU replacement
module cpu64_l1_refill_ctrl
    import cpu64_l1_refill_ctrl_pkg::*;
#(
    parameter int SETS_P    = SETS,
    parameter int INDEX_W_P = INDEX_W,
    parameter int TAG_W_P   = TAG_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_wr_valid_i,
    output logic                 cpu_wr_ready_o,
    input  logic [INDEX_W_P-1:0] cpu_wr_index_i,
    input  logic [2:0]           cpu_wr_word_i,
    input  logic [2:0]           cpu_wr_way_i,
    input  logic [TAG_W_P-1:0]   cpu_wr_tag_i,
    input  logic [1:0]           cpu_wr_state_i,
    input  logic [7:0]           cpu_wr_be_i,
    input  logic [63:0]          cpu_wr_data_i,
    input  logic                 miss_valid_i,
    output logic                 miss_ready_o,
    input  logic [INDEX_W_P-1:0] miss_index_i,
    input  logic [TAG_W_P-1:0]   miss_tag_i,
    input  logic [1:0]           miss_state_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [63:0]          wb_data_o,
    output logic [TAG_W_P-1:0]   wb_tag_o,
    output logic [INDEX_W_P-1:0] wb_index_o,
    output logic                 wb_last_o,
    input  logic                 fill_valid_i,
    output logic                 fill_ready_o,
    input  logic [63:0]          fill_data_i,
    output logic                 done_o,
    output logic [2:0]           done_way_o,
    output logic [INDEX_W_P-1:0] arr_index_o,
    output logic [2:0]           arr_word_sel_o,
    output logic [2:0]           arr_way_sel_o,
    output logic                 arr_write_en_o,
    output logic [1:0]           arr_state_o,
    output logic [7:0]           arr_be_o,
    output logic [TAG_W_P-1:0]   arr_tag_o,
    output logic [63:0]          arr_wdata_o,
    input  logic [63:0]          arr_rdata_selected_i,
    input  logic [TAG_W_P-1:0]   arr_tag_selected_i,
    input  logic [WAYS*2-1:0]    arr_state_way_flat_i
);

    fsm_e                 state_q;
    logic [2:0]           beat_q;
    logic                 fair_q;
    logic [2:0]           victim_q;
    logic [INDEX_W_P-1:0] idx_q;
    logic [TAG_W_P-1:0]   tag_q;
    logic [1:0]           mst_q;

    logic       live, idle, both, cpu_go, miss_go, wb_fire, fill_fire;
    logic [2:0] victim_way;
    logic       invalid_hit;
    logic [1:0] victim_state;

    assign live    = ~rst_i;
    assign idle    = (state_q == ST_IDLE);
    assign both    = cpu_wr_valid_i & miss_valid_i;
    // Contested IDLE cycle: fairness bit 0 favours the CPU store, 1 favours the miss.
    assign cpu_wr_ready_o = live & idle & ~(both & fair_q);
    assign miss_ready_o   = live & idle & ~(both & ~fair_q);
    assign cpu_go    = cpu_wr_valid_i & cpu_wr_ready_o;
    assign miss_go   = miss_valid_i & miss_ready_o;
    assign wb_fire   = wb_valid_o & wb_ready_i;
    assign fill_fire = fill_valid_i & fill_ready_o;
    assign wb_data_o = (live & wb_valid_o) ? arr_rdata_selected_i : 64'd0;
    assign victim_state = arr_state_way_flat_i[{victim_way, 1'b0} +: 2];

    cpu64_l1_victim_sel #(
        .SETS_P    (SETS_P),
        .INDEX_W_P (INDEX_W_P)
    ) u_victim_sel (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .index_i       (idx_q),
        .state_flat_i  (arr_state_way_flat_i),
        .use_i         (live && state_q == ST_VICTIM && !invalid_hit),
        .touch_i       (cpu_go || (live && state_q == ST_DONE)),
        .touch_index_i (cpu_go ? cpu_wr_index_i : idx_q),
        .touch_way_i   (cpu_go ? cpu_wr_way_i : victim_q),
        .victim_o      (victim_way),
        .invalid_hit_o (invalid_hit)
    );

    always_comb begin
        arr_index_o    = '0;
        arr_word_sel_o = 3'd0;
        arr_way_sel_o  = 3'd0;
        arr_write_en_o = 1'b0;
        arr_state_o    = MESI_N;
        arr_be_o       = 8'd0;
        arr_tag_o      = '0;
        arr_wdata_o    = 64'd0;
        if (live) begin
            case (state_q)
                ST_IDLE: if (cpu_go) begin
                    arr_index_o    = cpu_wr_index_i;
                    arr_word_sel_o = cpu_wr_word_i;
                    arr_way_sel_o  = cpu_wr_way_i;
                    arr_write_en_o = 1'b1;
                    arr_state_o    = cpu_wr_state_i;
                    arr_be_o       = cpu_wr_be_i;
                    arr_tag_o      = cpu_wr_tag_i;
                    arr_wdata_o    = cpu_wr_data_i;
                end
                ST_VICTIM: begin
                    arr_index_o   = idx_q;
                    arr_way_sel_o = victim_way;
                end
                ST_EVICT: begin
                    arr_index_o    = idx_q;
                    arr_way_sel_o  = victim_q;
                    arr_word_sel_o = beat_q;
                end
                ST_FILL: begin
                    arr_index_o    = idx_q;
                    arr_way_sel_o  = victim_q;
                    arr_word_sel_o = beat_q;
                    arr_write_en_o = fill_fire;
                    arr_be_o       = 8'hFF;
                    arr_tag_o      = tag_q;
                    arr_wdata_o    = fill_data_i;
                    // The line only turns valid with its final beat.
                    arr_state_o    = (beat_q == 3'd7) ? mst_q : MESI_N;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            beat_q       <= 3'd0;
            fair_q       <= 1'b0;
            victim_q     <= 3'd0;
            idx_q        <= '0;
            tag_q        <= '0;
            mst_q        <= 2'd0;
            wb_valid_o   <= 1'b0;
            wb_last_o    <= 1'b0;
            wb_tag_o     <= '0;
            wb_index_o   <= '0;
            fill_ready_o <= 1'b0;
            done_o       <= 1'b0;
            done_way_o   <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_go && both) fair_q <= 1'b1;
                    if (miss_go) begin
                        fair_q  <= 1'b0;
                        idx_q   <= miss_index_i;
                        tag_q   <= miss_tag_i;
                        mst_q   <= miss_state_i;
                        state_q <= ST_VICTIM;
                    end
                end
                ST_VICTIM: begin
                    victim_q   <= victim_way;
                    wb_tag_o   <= arr_tag_selected_i;
                    wb_index_o <= idx_q;
                    beat_q     <= 3'd0;
                    if (victim_state == MESI_TT) begin
                        state_q    <= ST_EVICT;
                        wb_valid_o <= 1'b1;
                    end else begin
                        state_q      <= ST_FILL;
                        fill_ready_o <= 1'b1;
                    end
                end
                ST_EVICT: if (wb_fire) begin
                    beat_q    <= beat_q + 3'd1;
                    wb_last_o <= (beat_q == 3'd6);
                    if (beat_q == 3'd7) begin
                        wb_valid_o   <= 1'b0;
                        state_q      <= ST_FILL;
                        fill_ready_o <= 1'b1;
                    end
                end
                ST_FILL: if (fill_fire) begin
                    beat_q <= beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        fill_ready_o <= 1'b0;
                        state_q      <= ST_DONE;
                        done_o       <= 1'b1;
                        done_way_o   <= victim_q;
                    end
                end
                ST_DONE: begin
                    done_o     <= 1'b0;
                    done_way_o <= 3'd0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu64_l1_refill_ctrl.sv
// tb/tb_cpu64_l1_refill_ctrl.sv - directed self-checking bench for cpu64_l1_refill_ctrl with an array model
module tb_cpu64_l1_refill_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_wr_valid_i, cpu_wr_ready_o;
    logic [4:0]  cpu_wr_index_i;
    logic [2:0]  cpu_wr_word_i, cpu_wr_way_i;
    logic [52:0] cpu_wr_tag_i;
    logic [1:0]  cpu_wr_state_i;
    logic [7:0]  cpu_wr_be_i;
    logic [63:0] cpu_wr_data_i;
    logic        miss_valid_i, miss_ready_o;
    logic [4:0]  miss_index_i;
    logic [52:0] miss_tag_i;
    logic [1:0]  miss_state_i;
    logic        wb_valid_o, wb_ready_i, wb_last_o;
    logic [63:0] wb_data_o;
    logic [52:0] wb_tag_o;
    logic [4:0]  wb_index_o;
    logic        fill_valid_i, fill_ready_o;
    logic [63:0] fill_data_i;
    logic        done_o;
    logic [2:0]  done_way_o;
    logic [4:0]  arr_index_o;
    logic [2:0]  arr_word_sel_o, arr_way_sel_o;
    logic        arr_write_en_o;
    logic [1:0]  arr_state_o;
    logic [7:0]  arr_be_o;
    logic [52:0] arr_tag_o;
    logic [63:0] arr_wdata_o;
    logic [63:0] arr_rdata_selected_i;
    logic [52:0] arr_tag_selected_i;
    logic [15:0] arr_state_way_flat_i;

    cpu64_l1_refill_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_wr_valid_i(cpu_wr_valid_i), .cpu_wr_ready_o(cpu_wr_ready_o),
        .cpu_wr_index_i(cpu_wr_index_i), .cpu_wr_word_i(cpu_wr_word_i),
        .cpu_wr_way_i(cpu_wr_way_i), .cpu_wr_tag_i(cpu_wr_tag_i),
        .cpu_wr_state_i(cpu_wr_state_i), .cpu_wr_be_i(cpu_wr_be_i),
        .cpu_wr_data_i(cpu_wr_data_i),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
        .miss_index_i(miss_index_i), .miss_tag_i(miss_tag_i), .miss_state_i(miss_state_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
        .wb_tag_o(wb_tag_o), .wb_index_o(wb_index_o), .wb_last_o(wb_last_o),
        .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o), .fill_data_i(fill_data_i),
        .done_o(done_o), .done_way_o(done_way_o),
        .arr_index_o(arr_index_o), .arr_word_sel_o(arr_word_sel_o), .arr_way_sel_o(arr_way_sel_o),
        .arr_write_en_o(arr_write_en_o), .arr_state_o(arr_state_o), .arr_be_o(arr_be_o),
        .arr_tag_o(arr_tag_o), .arr_wdata_o(arr_wdata_o),
        .arr_rdata_selected_i(arr_rdata_selected_i), .arr_tag_selected_i(arr_tag_selected_i),
        .arr_state_way_flat_i(arr_state_way_flat_i)
    );

    always #5 clk_i = ~clk_i;

    // Array model: data {idx,way,word}, tag/state {idx,way}
    logic [63:0] mem [2048];
    logic [52:0] tg  [256];
    logic [1:0]  st  [256];
    logic        cfg_init, cfg_en;
    logic [4:0]  cfg_idx;
    logic [15:0] cfg_flat;

    function automatic logic [63:0] pat(input logic [10:0] a);
        return 64'hD00D_0000_0000_0000 | {53'd0, a};
    endfunction

    function automatic logic [52:0] tpat(input logic [7:0] a);
        return 53'h1ABCD00000000 | {45'd0, a};
    endfunction

    assign arr_rdata_selected_i = mem[{arr_index_o, arr_way_sel_o, arr_word_sel_o}];
    assign arr_tag_selected_i   = tg[{arr_index_o, arr_way_sel_o}];

    always_comb begin
        arr_state_way_flat_i = 16'd0;
        for (int w = 0; w < 8; w++) arr_state_way_flat_i[2*w +: 2] = st[{arr_index_o, 3'(w)}];
    end

    always @(posedge clk_i) begin
        if (cfg_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= pat(11'(i));
            for (int j = 0; j < 256; j++) begin
                tg[j] <= tpat(8'(j));
                st[j] <= 2'd0;
            end
        end else if (cfg_en) begin
            for (int w = 0; w < 8; w++) st[{cfg_idx, 3'(w)}] <= cfg_flat[2*w +: 2];
        end else if (arr_write_en_o) begin
            for (int b = 0; b < 8; b++)
                if (arr_be_o[b])
                    mem[{arr_index_o, arr_way_sel_o, arr_word_sel_o}][8*b +: 8] <= arr_wdata_o[8*b +: 8];
            tg[{arr_index_o, arr_way_sel_o}] <= arr_tag_o;
            st[{arr_index_o, arr_way_sel_o}] <= arr_state_o;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_states(input logic [4:0] idx, input logic [15:0] flat);
        cfg_idx  = idx;
        cfg_flat = flat;
        cfg_en   = 1'b1;
        @(posedge clk_i); #1;
        cfg_en   = 1'b0;
    endtask

    int r_done_cyc, r_done_cnt, r_wb_beats, r_wb_last_cnt, r_wb_last_beat;
    int r_wb_bad_data, r_wb_unstable, r_fill_beats, r_fill_state_bad, r_acc_cyc;
    logic [2:0]  r_done_way, c1, c2;
    logic [1:0]  r_last_state;
    logic        r_busy;
    logic [52:0] r_wb_tag;
    logic [4:0]  r_wb_idx;

    task automatic run_miss(input logic [4:0] idx, input logic [52:0] tag, input logic [1:0] mst,
                            input logic contend, input int exp_victim, input int stall_beat,
                            input int reset_beat);
        int   stall_cnt = 0;
        logic [63:0] held = 64'd0;
        bit   have_held = 0;
        bit   accepted = 0;
        bit   did_reset = 0;
        r_done_cyc = 0; r_done_cnt = 0; r_wb_beats = 0; r_wb_last_cnt = 0; r_wb_last_beat = -1;
        r_wb_bad_data = 0; r_wb_unstable = 0; r_fill_beats = 0; r_fill_state_bad = 0; r_acc_cyc = 0;
        r_done_way = 3'd0; r_last_state = 2'd0; r_busy = 1'b1; c1 = 3'd0; c2 = 3'd0;
        r_wb_tag = '0; r_wb_idx = '0;
        miss_index_i = idx; miss_tag_i = tag; miss_state_i = mst; miss_valid_i = 1'b1;
        fill_valid_i = 1'b1; fill_data_i = 64'hF111_0000_0000_0000; wb_ready_i = 1'b1;
        if (contend) begin
            cpu_wr_valid_i = 1'b1; cpu_wr_index_i = 5'd8; cpu_wr_word_i = 3'd1; cpu_wr_way_i = 3'd1;
            cpu_wr_be_i = 8'hFF; cpu_wr_data_i = 64'h5555_AAAA_5555_AAAA; cpu_wr_state_i = 2'd3;
            cpu_wr_tag_i = tpat(8'h41);
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk_i);
            if (cyc == 1) c1 = {cpu_wr_ready_o, miss_ready_o, arr_write_en_o};
            if (cyc == 2) c2 = {cpu_wr_ready_o, miss_ready_o, arr_write_en_o};
            if (cyc == 5) r_busy = cpu_wr_ready_o | miss_ready_o;
            if (miss_valid_i && miss_ready_o) begin accepted = 1; r_acc_cyc = cyc; end
            if (wb_valid_o) begin
                if (have_held && wb_data_o !== held) r_wb_unstable++;
                if (!wb_ready_i) begin
                    held = wb_data_o; have_held = 1; stall_cnt++;
                end else begin
                    have_held = 0;
                    if (r_wb_beats == 0) begin r_wb_tag = wb_tag_o; r_wb_idx = wb_index_o; end
                    if (wb_data_o !== pat({idx, 3'(exp_victim), 3'(r_wb_beats)})) r_wb_bad_data++;
                    if (wb_last_o) begin r_wb_last_cnt++; r_wb_last_beat = r_wb_beats; end
                    r_wb_beats++;
                end
            end
            if (arr_write_en_o && fill_ready_o) begin
                if (r_fill_beats < 7 && arr_state_o !== 2'd0) r_fill_state_bad++;
                if (r_fill_beats == 7) r_last_state = arr_state_o;
                r_fill_beats++;
            end
            if (done_o) begin
                r_done_cnt++;
                if (r_done_cyc == 0) begin r_done_cyc = cyc; r_done_way = done_way_o; end
            end
            @(posedge clk_i); #1;
            if (accepted) miss_valid_i = 1'b0;
            if (cyc == 2) cpu_wr_valid_i = 1'b0;
            rst_i = 1'b0;
            if (reset_beat >= 0 && r_fill_beats == reset_beat + 1 && !did_reset) begin
                rst_i = 1'b1; did_reset = 1;
            end
            fill_data_i = 64'hF111_0000_0000_0000 | 64'(r_fill_beats);
            wb_ready_i  = !(stall_beat >= 0 && r_wb_beats == stall_beat && stall_cnt < 3);
            if (r_done_cyc != 0 && cyc >= r_done_cyc + 2) break;
        end
        miss_valid_i = 1'b0; cpu_wr_valid_i = 1'b0; fill_valid_i = 1'b0; wb_ready_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1; cfg_init = 1'b1; cfg_en = 1'b0; cfg_idx = '0; cfg_flat = '0;
        cpu_wr_valid_i = 0; cpu_wr_index_i = 0; cpu_wr_word_i = 0; cpu_wr_way_i = 0;
        cpu_wr_tag_i = 0; cpu_wr_state_i = 0; cpu_wr_be_i = 0; cpu_wr_data_i = 0;
        miss_valid_i = 0; miss_index_i = 0; miss_tag_i = 0; miss_state_i = 0;
        wb_ready_i = 1; fill_valid_i = 0; fill_data_i = 0;
        @(posedge clk_i); #1;
        cfg_init = 1'b0;
        cpu_wr_valid_i = 1'b1; miss_valid_i = 1'b1;
        @(negedge clk_i);
        check("rst_cpu_ready", 64'(cpu_wr_ready_o), 64'd0);
        check("rst_miss_ready", 64'(miss_ready_o), 64'd0);
        check("rst_outs", 64'({wb_valid_o, fill_ready_o, done_o, arr_write_en_o, wb_last_o}), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; cpu_wr_valid_i = 1'b0; miss_valid_i = 1'b0;

        // 1: single-cycle CPU store, partial byte enables
        cpu_wr_valid_i = 1'b1; cpu_wr_index_i = 5'd3; cpu_wr_word_i = 3'd5; cpu_wr_way_i = 3'd2;
        cpu_wr_be_i = 8'h0F; cpu_wr_data_i = 64'h1122_3344_5566_7788; cpu_wr_state_i = 2'd3;
        cpu_wr_tag_i = tpat(8'h1A);
        @(negedge clk_i);
        check("t1_ready", 64'(cpu_wr_ready_o), 64'd1);
        check("t1_wen", 64'(arr_write_en_o), 64'd1);
        check("t1_addr", 64'({arr_index_o, arr_way_sel_o, arr_word_sel_o, arr_be_o}), 64'({5'd3, 3'd2, 3'd5, 8'h0F}));
        @(posedge clk_i); #1;
        cpu_wr_valid_i = 1'b0;
        @(negedge clk_i);
        check("t1_mem", mem[{5'd3, 3'd2, 3'd5}], 64'hD00D_0000_5566_7788);
        check("t1_state", 64'(st[{5'd3, 3'd2}]), 64'd3);
        @(posedge clk_i); #1;

        // 2: clean set, round-robin way 0
        set_states(5'd4, 16'h5555);
        run_miss(5'd4, tpat(8'hA4), 2'd3, 1'b0, 0, -1, -1);
        check("t2_c1", 64'(c1), 64'(3'b110));
        check("t2_busy", 64'(r_busy), 64'd0);
        check("t2_done_cyc", 64'(r_done_cyc), 64'd11);
        check("t2_done_cnt", 64'(r_done_cnt), 64'd1);
        check("t2_done_way", 64'(r_done_way), 64'd0);
        check("t2_wb_beats", 64'(r_wb_beats), 64'd0);
        check("t2_fill_beats", 64'(r_fill_beats), 64'd8);
        check("t2_state_n", 64'(r_fill_state_bad), 64'd0);
        check("t2_last_state", 64'(r_last_state), 64'd3);
        check("t2_mem0", mem[{5'd4, 3'd0, 3'd0}], 64'hF111_0000_0000_0000);
        check("t2_mem7", mem[{5'd4, 3'd0, 3'd7}], 64'hF111_0000_0000_0007);
        check("t2_tag", 64'(tg[{5'd4, 3'd0}]), 64'(tpat(8'hA4)));

        // 3: invalid way 3 chosen over TT ways
        set_states(5'd5, 16'hFF3F);
        run_miss(5'd5, tpat(8'hA5), 2'd2, 1'b0, 3, -1, -1);
        check("t3_done_way", 64'(r_done_way), 64'd3);
        check("t3_wb_beats", 64'(r_wb_beats), 64'd0);
        check("t3_done_cyc", 64'(r_done_cyc), 64'd11);
        check("t3_state", 64'(st[{5'd5, 3'd3}]), 64'd2);

        // 4: dirty victim (round-robin way 1), 3-cycle stall on beat 2
        set_states(5'd6, 16'hFFFF);
        run_miss(5'd6, tpat(8'hA6), 2'd3, 1'b0, 1, 2, -1);
        check("t4_wb_beats", 64'(r_wb_beats), 64'd8);
        check("t4_wb_data", 64'(r_wb_bad_data), 64'd0);
        check("t4_stable", 64'(r_wb_unstable), 64'd0);
        check("t4_last_cnt", 64'(r_wb_last_cnt), 64'd1);
        check("t4_last_beat", 64'(r_wb_last_beat), 64'd7);
        check("t4_wb_tag", 64'(r_wb_tag), 64'(tpat({5'd6, 3'd1})));
        check("t4_wb_idx", 64'(r_wb_idx), 64'd6);
        check("t4_done_cyc", 64'(r_done_cyc), 64'd22);
        check("t4_done_way", 64'(r_done_way), 64'd1);
        check("t4_fill_beats", 64'(r_fill_beats), 64'd8);

        // 5: contention twice, fairness alternates
        set_states(5'd7, 16'h5555);
        run_miss(5'd7, tpat(8'hA7), 2'd1, 1'b1, 2, -1, -1);
        check("t5a_c1", 64'(c1), 64'(3'b101));
        check("t5a_c2", 64'(c2), 64'(3'b010));
        check("t5a_acc", 64'(r_acc_cyc), 64'd2);
        check("t5a_done_cyc", 64'(r_done_cyc), 64'd12);
        check("t5a_done_way", 64'(r_done_way), 64'd2);
        check("t5a_cpu_mem", mem[{5'd8, 3'd1, 3'd1}], 64'h5555_AAAA_5555_AAAA);
        run_miss(5'd7, tpat(8'hB7), 2'd1, 1'b1, 3, -1, -1);
        check("t5b_c1", 64'(c1), 64'(3'b101));
        check("t5b_c2", 64'(c2), 64'(3'b010));
        check("t5b_done_way", 64'(r_done_way), 64'd3);

        // 6: reset after fill beat 4
        set_states(5'd9, 16'h5555);
        run_miss(5'd9, tpat(8'hA9), 2'd3, 1'b0, 4, -1, 4);
        check("t6_done_cnt", 64'(r_done_cnt), 64'd0);
        check("t6_fill_beats", 64'(r_fill_beats), 64'd5);
        check("t6_state_n", 64'(st[{5'd9, 3'd4}]), 64'd0);
        @(negedge clk_i);
        check("t6_idle_ready", 64'({cpu_wr_ready_o, miss_ready_o, fill_ready_o}), 64'(3'b110));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
